// File: rtl/calc_sequencer_if.sv
// Keypad/entry/ALU signal bundle for the calculator sequencer.
// master = sequencer side, slave = entry block / ALU / display side.
interface calc_sequencer_if;
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] num_o;
  logic [15:0] num_A;
  logic        a_strobe;
  logic [15:0] num_B;
  logic        b_strobe;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        alu_start;
  logic        alu_abort;
  logic        busy;
  logic        result_valid;
  logic        error;
  logic [31:0] disp_val;

  modport master (
    input  key, key_valid, num_o, num_A, a_strobe, num_B, b_strobe,
           alu_done, alu_result,
    output op_a, op_b, alu_start, alu_abort, busy, result_valid, error,
           disp_val
  );

  modport slave (
    output key, key_valid, num_o, num_A, a_strobe, num_B, b_strobe,
           alu_done, alu_result,
    input  op_a, op_b, alu_start, alu_abort, busy, result_valid, error,
           disp_val
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator operand capture / ALU issue / result display sequencer.
// state | meaning: IDLE wait A | WAIT_B wait B | ISSUE start pulse | WAIT_DONE watchdog | SHOW result | ERROR timeout
module calc_sequencer #(
  parameter int         TIMEOUT   = 64,
  parameter logic [3:0] CLEAR_KEY = 4'b1010,
  parameter logic [3:0] ENTER_KEY = 4'b1011
) (
  input logic               clk,
  input logic               rst,
  calc_sequencer_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_B    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    SHOW      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      op_a_q, op_a_d;
  logic [15:0]      op_b_q, op_b_d;
  logic [31:0]      res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic clear_key, enter_key;
  assign clear_key = bus.key_valid && (bus.key == CLEAR_KEY);
  assign enter_key = bus.key_valid && (bus.key == ENTER_KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    if (clear_key) begin
      // Clear beats every other event; the ALU only needs an abort if it was started.
      state_d = IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
      res_d   = '0;
      abort_d = (state_q == ISSUE) || (state_q == WAIT_DONE);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.a_strobe) begin
            op_a_d  = bus.num_A;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.b_strobe) begin
            op_b_d  = bus.num_B;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.alu_done) begin
            res_d   = bus.alu_result;
            state_d = SHOW;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = ERROR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW, ERROR: begin
          if (enter_key) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.op_a         = op_a_q;
    bus.op_b         = op_b_q;
    bus.alu_abort    = abort_q;
    bus.alu_start    = (state_q == ISSUE);
    bus.busy         = (state_q == ISSUE) || (state_q == WAIT_DONE);
    bus.result_valid = (state_q == SHOW);
    bus.error        = (state_q == ERROR);
    case (state_q)
      IDLE, WAIT_B:     bus.disp_val = {16'h0, bus.num_o};
      SHOW:             bus.disp_val = res_q;
      ERROR:            bus.disp_val = 32'hFFFF_FFFF;
      default:          bus.disp_val = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: one instance at TIMEOUT=64, one at TIMEOUT=8,
// both fed the same stimulus and resynchronised by reset between scenarios.
module tb_calc_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] num_o;
  logic [15:0] num_A;
  logic        a_strobe;
  logic [15:0] num_B;
  logic        b_strobe;
  logic        alu_done;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int start_cnt;

  localparam logic [3:0] CLR = 4'b1010;
  localparam logic [3:0] ENT = 4'b1011;

  calc_sequencer_if bus64 ();
  calc_sequencer_if bus8 ();

  assign bus64.key = key;           assign bus8.key = key;
  assign bus64.key_valid = key_valid; assign bus8.key_valid = key_valid;
  assign bus64.num_o = num_o;       assign bus8.num_o = num_o;
  assign bus64.num_A = num_A;       assign bus8.num_A = num_A;
  assign bus64.a_strobe = a_strobe; assign bus8.a_strobe = a_strobe;
  assign bus64.num_B = num_B;       assign bus8.num_B = num_B;
  assign bus64.b_strobe = b_strobe; assign bus8.b_strobe = b_strobe;
  assign bus64.alu_done = alu_done; assign bus8.alu_done = alu_done;
  assign bus64.alu_result = alu_result; assign bus8.alu_result = alu_result;

  calc_sequencer #(.TIMEOUT(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
  calc_sequencer #(.TIMEOUT(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    key = k; key_valid = 1'b1;
    step();
    key_valid = 1'b0; key = 4'h0;
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    num_A = a; a_strobe = 1'b1;
    step();
    a_strobe = 1'b0;
    num_B = b; b_strobe = 1'b1;
    step();
    b_strobe = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  {31'h0, bus64.busy},         32'h0);
    chk({tag, "_rv"},    {31'h0, bus64.result_valid}, 32'h0);
    chk({tag, "_err"},   {31'h0, bus64.error},        32'h0);
    chk({tag, "_start"}, {31'h0, bus64.alu_start},    32'h0);
    chk({tag, "_abort"}, {31'h0, bus64.alu_abort},    32'h0);
    chk({tag, "_opa"},   {16'h0, bus64.op_a},         32'h0);
    chk({tag, "_opb"},   {16'h0, bus64.op_b},         32'h0);
    chk({tag, "_disp"},  bus64.disp_val,              {16'h0, num_o});
  endtask

  initial begin
    rst = 1'b1; key = 4'h0; key_valid = 1'b0; num_o = 16'h1234;
    num_A = 16'h0; a_strobe = 1'b0; num_B = 16'h0; b_strobe = 1'b0;
    alu_done = 1'b0; alu_result = 32'h0;
    step();
    rst = 1'b0;
    check_reset("reset");

    // Normal flow: done 10 cycles after start
    load_ops(16'd123, 16'd45);
    chk("nf_opa", {16'h0, bus64.op_a}, 32'd123);
    chk("nf_opb", {16'h0, bus64.op_b}, 32'd45);
    busy_cnt = 0; start_cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) begin alu_done = 1'b1; alu_result = 32'd5535; end
      busy_cnt  += int'(bus64.busy);
      start_cnt += int'(bus64.alu_start);
      step();
      alu_done = 1'b0;
    end
    chk("nf_busy_cycles", busy_cnt, 32'd11);
    chk("nf_starts", start_cnt, 32'd1);
    chk("nf_rv", {31'h0, bus64.result_valid}, 32'h1);
    chk("nf_disp", bus64.disp_val, 32'd5535);
    chk("nf_busy_after", {31'h0, bus64.busy}, 32'h0);
    num_o = 16'h00AB;
    press(ENT);
    chk("nf_enter_rv", {31'h0, bus64.result_valid}, 32'h0);
    chk("nf_enter_disp", bus64.disp_val, 32'h0000_00AB);
    num_o = 16'h4321;
    #1;
    chk("nf_disp_follow", bus64.disp_val, 32'h0000_4321);

    // Timeout on the TIMEOUT=8 instance
    do_reset();
    load_ops(16'd1, 16'd2);
    step();
    for (int i = 0; i < 7; i++) step();
    chk("to_busy_w7", {31'h0, bus8.busy}, 32'h1);
    chk("to_err_w7", {31'h0, bus8.error}, 32'h0);
    step();
    chk("to_err_w8", {31'h0, bus8.error}, 32'h1);
    chk("to_disp", bus8.disp_val, 32'hFFFF_FFFF);
    chk("to_busy_w8", {31'h0, bus8.busy}, 32'h0);
    alu_done = 1'b1; alu_result = 32'd99;
    step();
    alu_done = 1'b0;
    chk("to_late_err", {31'h0, bus8.error}, 32'h1);
    chk("to_late_disp", bus8.disp_val, 32'hFFFF_FFFF);
    chk("to_late_rv", {31'h0, bus8.result_valid}, 32'h0);
    press(ENT);
    chk("to_enter_err", {31'h0, bus8.error}, 32'h0);
    chk("to_enter_disp", bus8.disp_val, {16'h0, num_o});

    // Done arriving in the same cycle the counter reaches TIMEOUT-1
    do_reset();
    load_ops(16'd3, 16'd4);
    step();
    for (int i = 0; i < 7; i++) step();
    alu_done = 1'b1; alu_result = 32'd7;
    step();
    alu_done = 1'b0;
    chk("col_rv", {31'h0, bus8.result_valid}, 32'h1);
    chk("col_disp", bus8.disp_val, 32'd7);
    chk("col_err", {31'h0, bus8.error}, 32'h0);

    // Clear during WAIT_DONE, cycle 3
    do_reset();
    load_ops(16'd3, 16'd4);
    step();
    for (int i = 0; i < 3; i++) step();
    press(CLR);
    chk("ab_abort", {31'h0, bus64.alu_abort}, 32'h1);
    chk("ab_abort8", {31'h0, bus8.alu_abort}, 32'h1);
    chk("ab_busy", {31'h0, bus64.busy}, 32'h0);
    chk("ab_opa", {16'h0, bus64.op_a}, 32'h0);
    chk("ab_opb", {16'h0, bus64.op_b}, 32'h0);
    chk("ab_disp", bus64.disp_val, {16'h0, num_o});
    step();
    chk("ab_abort_gone", {31'h0, bus64.alu_abort}, 32'h0);

    // Clear during WAIT_B: no abort, then back in IDLE a B strobe is ignored
    do_reset();
    num_A = 16'd77; a_strobe = 1'b1;
    step();
    a_strobe = 1'b0;
    press(CLR);
    chk("cb_abort", {31'h0, bus64.alu_abort}, 32'h0);
    chk("cb_opa", {16'h0, bus64.op_a}, 32'h0);
    num_B = 16'd8; b_strobe = 1'b1;
    step();
    b_strobe = 1'b0;
    chk("cb_b_ignored", {31'h0, bus64.alu_start}, 32'h0);
    chk("cb_b_opb", {16'h0, bus64.op_b}, 32'h0);

    // Simultaneous strobes in IDLE, extra A strobe in WAIT_B, stray done in IDLE
    do_reset();
    num_A = 16'd9; num_B = 16'd4; a_strobe = 1'b1; b_strobe = 1'b1;
    step();
    a_strobe = 1'b0; b_strobe = 1'b0;
    chk("ig_opa", {16'h0, bus64.op_a}, 32'd9);
    chk("ig_opb", {16'h0, bus64.op_b}, 32'd0);
    chk("ig_start", {31'h0, bus64.alu_start}, 32'h0);
    num_A = 16'd5; a_strobe = 1'b1;
    step();
    a_strobe = 1'b0;
    chk("ig_opa2", {16'h0, bus64.op_a}, 32'd9);
    press(CLR);
    alu_done = 1'b1; alu_result = 32'hDEAD;
    step();
    alu_done = 1'b0;
    chk("ig_stray_disp", bus64.disp_val, {16'h0, num_o});
    chk("ig_stray_rv", {31'h0, bus64.result_valid}, 32'h0);

    // Reset mid-operation: WAIT_DONE, then SHOW
    do_reset();
    load_ops(16'd11, 16'd22);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rst_wd");
    load_ops(16'd11, 16'd22);
    step();
    alu_done = 1'b1; alu_result = 32'h55;
    step();
    alu_done = 1'b0;
    chk("rst_show_rv", {31'h0, bus64.result_valid}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rst_show");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Controller sitting between the keypad number-entry block and the arithmetic unit of the calculator. Captures operand A and operand B as the entry block qualifies them, issues a single start pulse to the arithmetic unit, waits for its done with a watchdog timeout, then holds the result for display until the user acknowledges it. It also selects what the display shows: the live entry value while operands are being typed, or the latched result afterwards.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT_DONE before declaring an error; legal range 2..1024.
- CLEAR_KEY, 4'b1010: key code that aborts from any state.
- ENTER_KEY, 4'b1011: key code that acknowledges a result or error.

- clk  in  1  system clock. One clock domain; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  4  keypad code.
- key_valid  in  1  qualifies `key` for exactly one cycle.
- num_o  in  16  live entry value from the number-entry block.
- num_A  in  16  operand A; valid only in a cycle where `a_strobe`=1.
- a_strobe  in  1  one-cycle qualifier for `num_A`.
- num_B  in  16  operand B; valid only in a cycle where `b_strobe`=1.
- b_strobe  in  1  one-cycle qualifier for `num_B`. This is the entry block's `signal_num`.
- alu_done  in  1  arithmetic unit has finished; `alu_result` is valid in that same cycle.
- alu_result  in  32  arithmetic result.
- op_a  out  16  registered operand A.
- op_b  out  16  registered operand B.
- alu_start  out  1  one-cycle start pulse.
- alu_abort  out  1  one-cycle abort pulse.
- busy  out  1  high in ISSUE or WAIT_DONE.
- result_valid  out  1  high in SHOW.
- error  out  1  high in ERROR.
- disp_val  out  32  display value.

## Operation

**Reset values.** In the cycle after `rst`=1:
- state=IDLE;
- `op_a`=0, `op_b`=0, result register=0, timeout counter=0;
- `alu_start`=0, `alu_abort`=0, `busy`=0, `result_valid`=0, `error`=0;
- `disp_val`={16'h0, `num_o`}.

**States.** The state is fully registered. Outputs decode from state and registers only; there is no combinational path from inputs to outputs except `disp_val`, which passes `num_o` through.

**Global abort.**
- `key_valid` && `key`==CLEAR_KEY in any state → IDLE next cycle.
- This has the highest priority.
- `op_a`, `op_b` and the result register clear to 0.
- If the current state is ISSUE or WAIT_DONE, `alu_abort`=1 for the next cycle only.

**Transitions.**
- IDLE:
  - `a_strobe` → `op_a`<=`num_A`, go to WAIT_B.
  - `b_strobe` is ignored, including when it arrives in the same cycle as `a_strobe`.
- WAIT_B:
  - `b_strobe` → `op_b`<=`num_B`, go to ISSUE.
  - Further `a_strobe` pulses are ignored.
- ISSUE:
  - Lasts exactly one cycle, with `alu_start`=1.
  - Counter<=0, go to WAIT_DONE unconditionally.
- WAIT_DONE:
  - `alu_done` → result register<=`alu_result`, go to SHOW.
  - Otherwise, when counter==TIMEOUT-1, go to ERROR.
  - Otherwise, counter+1.
  - If `alu_done` arrives in the same cycle as the timeout, `alu_done` wins.
- SHOW:
  - `key_valid` && `key`==ENTER_KEY → IDLE.
  - All other keys and strobes are ignored.
- ERROR:
  - `key_valid` && `key`==ENTER_KEY → IDLE.
  - `alu_done` is ignored.
- Illegal state encoding → IDLE.

**Extra pulses.** `alu_done` outside WAIT_DONE is ignored and changes no register.

**Display select.**
- IDLE or WAIT_B: `disp_val`={16'h0, `num_o`}.
- ISSUE or WAIT_DONE: 0.
- SHOW: result register.
- ERROR: 32'hFFFF_FFFF.

**Counter.** Width is clog2(TIMEOUT)+1 bits. It never wraps, because WAIT_DONE always exits at TIMEOUT-1.

## Timing
- `a_strobe` at cycle t → `op_a` is valid and state=WAIT_B at t+1.
- `b_strobe` at cycle t → `op_b` is valid and ISSUE at t+1 (`alu_start`=1 in t+1 only), then WAIT_DONE at t+2.
- `op_a` and `op_b` are stable from ISSUE until the next IDLE.
- `alu_done` at cycle d → SHOW at d+1, with `result_valid`=1 and `disp_val`=result.
- With no `alu_done`: WAIT_DONE entered at w → ERROR at w+TIMEOUT.
- Clear at t → IDLE at t+1; `alu_abort`, if generated, is high only in t+1.
- `rst` mid-operation (any state) → reset values at the next edge. No `alu_abort` is generated on reset.

## Test plan
- **Normal flow.** Reset, then:
  - `a_strobe` with `num_A`=123, then `b_strobe` with `num_B`=45;
  - the ALU model asserts `alu_done` 10 cycles after `alu_start` with `alu_result`=5535.
  - Required: `op_a`=123, `op_b`=45; exactly one `alu_start`; `busy` for 11 cycles; `disp_val`=5535 with `result_valid` the cycle after done; ENTER_KEY → IDLE, and `disp_val` follows `num_o`.
- **Timeout.** TIMEOUT=8 with no `alu_done`.
  - Required: ERROR exactly 8 cycles after entering WAIT_DONE; `error`=1, `disp_val`=32'hFFFF_FFFF.
  - A late `alu_done` changes nothing; ENTER_KEY → IDLE.
- **Done/timeout collision.** `alu_done` with `alu_result`=7 in the cycle where counter==TIMEOUT-1.
  - Required: SHOW with result 7, `error`=0.
- **Abort.** CLEAR_KEY during WAIT_DONE (cycle 3).
  - Required: IDLE next cycle; `alu_abort` is a one-cycle pulse; `op_a`=`op_b`=0.
  - Also: CLEAR_KEY in WAIT_B → IDLE with no `alu_abort`.
- **Ignored strobes.** `a_strobe` and `b_strobe` together in IDLE with `num_A`=9, `num_B`=4.
  - Required: WAIT_B with `op_a`=9 and `op_b`=0.
  - A second `a_strobe` (`num_A`=5) in WAIT_B leaves `op_a`=9.
  - A stray `alu_done` in IDLE leaves `disp_val`={16'h0, `num_o`}.
- **Reset mid-operation.** `rst` during WAIT_DONE and again during SHOW.
  - Required: all outputs at their reset values one cycle later; no `alu_start` and no `alu_abort`.
